gcd_result_collector: RTL and testbench

Downstream stage for the GCD engine. Consumes each result the engine presents on its `gcd_out`/`gcd_valid` output and answers with a one-cycle `ack` pulse. Buffers accepted results in a small FIFO and re-presents them on a valid/ready stream. Keeps running statistics (total results, coprime results) for the test and debug logic.

---
 rtl/gcd_pkg.sv | 16 +
 rtl/gcd_result_fifo.sv | 62 ++++++
 rtl/gcd_result_collector.sv | 83 ++++++++
 tb/tb_gcd_result_collector.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine and its downstream result collector.
package gcd_pkg;

   localparam int GCD_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACK       = 2'd1,
      WAIT_DROP = 2'd2
   } gcd_state_t;

   function automatic logic is_coprime(input logic [GCD_WIDTH-1:0] g);
      return g == GCD_WIDTH'(1);
   endfunction

endpackage

// File: rtl/gcd_result_fifo.sv
// Circular-buffer FIFO with first-word fall-through read of registered storage.
// Push is ignored when full and pop when empty; level is the occupancy counter.
module gcd_result_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             push_ok, pop_ok;

   assign full_o    = (level_q == LW'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign push_ok   = push_i && !full_o;
   assign pop_ok    = pop_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign level_o   = level_q;

   // DEPTH is a power of two, so natural pointer overflow wraps DEPTH-1 to 0.
   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/gcd_result_collector.sv
// Acknowledges GCD engine results with a one-cycle ack, buffers them in a FIFO
// and keeps result/coprime statistics; capture stalls (no ack) while the FIFO is full.
module gcd_result_collector
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic [WIDTH-1:0]         gcd_out,
   input  logic                     gcd_valid,
   output logic                     ack,
   output logic [WIDTH-1:0]         res_data,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         res_count,
   output logic [CNT_W-1:0]         coprime_count
);

   gcd_state_t       state_q, state_d;
   logic [CNT_W-1:0] res_count_q, res_count_d;
   logic [CNT_W-1:0] coprime_count_q, coprime_count_d;
   logic             fifo_full, fifo_empty;
   logic             capture;

   // Only IDLE may capture, so a result still held high after ack is not taken twice.
   assign capture = (state_q == IDLE) && gcd_valid && !fifo_full;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (capture) state_d = ACK;
         ACK:       state_d = WAIT_DROP;
         WAIT_DROP: if (!gcd_valid) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      res_count_d     = res_count_q;
      coprime_count_d = coprime_count_q;
      if (capture) begin
         res_count_d = res_count_q + CNT_W'(1);
         if (gcd_out == WIDTH'(1)) coprime_count_d = coprime_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q         <= IDLE;
         res_count_q     <= '0;
         coprime_count_q <= '0;
      end else begin
         state_q         <= state_d;
         res_count_q     <= res_count_d;
         coprime_count_q <= coprime_count_d;
      end
   end

   gcd_result_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .Clk       (Clk),
      .Rst       (Rst),
      .push_i    (capture),
      .wr_data_i (gcd_out),
      .pop_i     (res_ready),
      .rd_data_o (res_data),
      .level_o   (level),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign ack           = (state_q == ACK);
   assign res_valid     = !fifo_empty;
   assign res_count     = res_count_q;
   assign coprime_count = coprime_count_q;

endmodule

// File: tb/tb_gcd_result_collector.sv
// Bench for gcd_result_collector: fixed vectors, directed corner sequences and
// randomized engine traffic checked each cycle against a queue-based reference.
module tb_gcd_result_collector;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int CW = 4;

   logic          Clk = 1'b0;
   logic          Rst;
   logic [W-1:0]  gcd_out;
   logic          gcd_valid;
   logic          ack;
   logic [W-1:0]  res_data;
   logic          res_valid;
   logic          res_ready;
   logic [2:0]    level;
   logic [CW-1:0] res_count;
   logic [CW-1:0] coprime_count;

   gcd_result_collector #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .gcd_out       (gcd_out),
      .gcd_valid     (gcd_valid),
      .ack           (ack),
      .res_data      (res_data),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .level         (level),
      .res_count     (res_count),
      .coprime_count (coprime_count)
   );

   always #5 Clk = ~Clk;

   int tests = 0;
   int fails = 0;

   // Reference: queue of buffered results, handshake phase (0 ready, 1 acking, 2 waiting drop).
   int mq[$];
   int m_phase, m_rc, m_cc;
   bit rand_ready = 1'b0;
   bit last_ack;
   int s_ack, s_lvl, s_rv, s_rd, s_rc, s_cc;

   typedef struct {
      bit v; int d; bit r;
      bit e_ack; int e_lvl; bit e_rv; int e_rd; int e_rc; int e_cc;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_phase = 0;
      m_rc    = 0;
      m_cc    = 0;
   endtask

   task automatic model_update();
      bit full, pop, cap;
      full = (mq.size() == D);
      pop  = (mq.size() > 0) && res_ready;
      cap  = (m_phase == 0) && gcd_valid && !full;
      if (pop) void'(mq.pop_front());
      if (cap) begin
         mq.push_back(int'(gcd_out));
         m_rc = (m_rc + 1) % (1 << CW);
         if (gcd_out == 1) m_cc = (m_cc + 1) % (1 << CW);
      end
      if (m_phase == 1)                     m_phase = 2;
      else if (m_phase == 2 && !gcd_valid)  m_phase = 0;
      else if (m_phase == 0 && cap)         m_phase = 1;
   endtask

   task automatic step();
      @(negedge Clk);
      s_ack = int'(ack); s_lvl = int'(level); s_rv = int'(res_valid);
      s_rd  = int'(res_data); s_rc = int'(res_count); s_cc = int'(coprime_count);
      chk("ack", s_ack, (m_phase == 1) ? 1 : 0);
      chk("res_valid", s_rv, (mq.size() != 0) ? 1 : 0);
      chk("level", s_lvl, mq.size());
      chk("res_count", s_rc, m_rc);
      chk("coprime_count", s_cc, m_cc);
      if (mq.size() != 0) chk("res_data", s_rd, mq[0]);
      last_ack = ack;
      if (Rst) model_update();
      @(posedge Clk);
      #1;
      if (rand_ready) res_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      Rst = 1'b0;
      model_reset();
      repeat (3) step();
      Rst = 1'b1;
   endtask

   // Engine model: present v, hold until ack, keep valid for 'hold' extra cycles, then drop.
   task automatic present(input int v, input int hold);
      int n;
      gcd_valid = 1'b1;
      gcd_out   = W'(v);
      n = 0;
      do begin
         step();
         n++;
      end while (!last_ack && n < 200);
      chk("engine_ack_seen", int'(last_ack), 1);
      repeat (hold) step();
      gcd_valid = 1'b0;
      step();
   endtask

   function automatic int gcd(input int a, input int b);
      int t;
      while (b != 0) begin
         t = a % b; a = b; b = t;
      end
      return a;
   endfunction

   vec_t vecs[10];

   initial begin
      vecs[0] = '{1, 12, 0, 0, 0, 0, 0,  0, 0};
      vecs[1] = '{1, 12, 0, 1, 1, 1, 12, 1, 0};
      vecs[2] = '{0, 0,  0, 0, 1, 1, 12, 1, 0};
      vecs[3] = '{0, 0,  1, 0, 1, 1, 12, 1, 0};
      vecs[4] = '{0, 0,  0, 0, 0, 0, 0,  1, 0};
      vecs[5] = '{1, 1,  1, 0, 0, 0, 0,  1, 0};
      vecs[6] = '{1, 1,  0, 1, 1, 1, 1,  2, 1};
      vecs[7] = '{0, 0,  0, 0, 1, 1, 1,  2, 1};
      vecs[8] = '{0, 0,  1, 0, 1, 1, 1,  2, 1};
      vecs[9] = '{0, 0,  0, 0, 0, 0, 0,  2, 1};

      gcd_valid = 1'b0;
      gcd_out   = '0;
      res_ready = 1'b0;

      // Reset then idle.
      do_reset();
      repeat (10) step();

      // Single result (12) then a coprime result pushed into an empty FIFO with ready high.
      for (int i = 0; i < 10; i++) begin
         gcd_valid = vecs[i].v;
         gcd_out   = W'(vecs[i].d);
         res_ready = vecs[i].r;
         step();
         chk($sformatf("vec%0d_ack", i), s_ack, int'(vecs[i].e_ack));
         chk($sformatf("vec%0d_level", i), s_lvl, vecs[i].e_lvl);
         chk($sformatf("vec%0d_res_valid", i), s_rv, int'(vecs[i].e_rv));
         if (vecs[i].e_rv) chk($sformatf("vec%0d_res_data", i), s_rd, vecs[i].e_rd);
         chk($sformatf("vec%0d_res_count", i), s_rc, vecs[i].e_rc);
         chk($sformatf("vec%0d_coprime_count", i), s_cc, vecs[i].e_cc);
      end

      // Fill and stall.
      do_reset();
      res_ready = 1'b0;
      present(6, 0); present(1, 0); present(9, 0); present(4, 0);
      chk("fill_level", int'(level), 4);
      gcd_valid = 1'b1;
      gcd_out   = W'(5);
      repeat (5) step();
      chk("stall_no_ack", int'(ack), 0);
      chk("stall_level", int'(level), 4);
      res_ready = 1'b1;
      present(5, 0);
      repeat (4) step();
      chk("fill_res_count", int'(res_count), 5);
      chk("fill_coprime_count", int'(coprime_count), 1);
      chk("fill_drained", int'(level), 0);

      // Held gcd_valid after ack captures exactly once.
      res_ready = 1'b0;
      present(7, 5);
      repeat (2) step();
      chk("held_level", int'(level), 1);
      chk("held_data", int'(res_data), 7);

      // Simultaneous push/pop at level 2, enough rounds to wrap both pointers.
      present(20, 0);
      chk("pp_start_level", int'(level), 2);
      for (int i = 0; i < 2 * D; i++) begin
         gcd_valid = 1'b1;
         gcd_out   = W'(30 + i);
         res_ready = 1'b1;
         step();
         res_ready = 1'b0;
         step();
         gcd_valid = 1'b0;
         step();
         chk("pp_level", int'(level), 2);
      end

      // Randomized engine traffic with random consumer backpressure.
      do_reset();
      rand_ready = 1'b1;
      repeat (40) begin
         int a, b;
         a = $urandom_range(1, 200);
         b = $urandom_range(1, 200);
         present(($urandom_range(0, 3) == 0) ? 1 : gcd(a, b), $urandom_range(0, 2));
      end
      rand_ready = 1'b0;
      res_ready  = 1'b1;
      repeat (6) step();

      // Counter wrap with 4-bit counters.
      do_reset();
      res_ready = 1'b1;
      repeat (17) present(1, 0);
      chk("wrap_res_count", int'(res_count), 1);
      chk("wrap_coprime_count", int'(coprime_count), 1);

      // Asynchronous reset while ack is high.
      res_ready = 1'b0;
      gcd_valid = 1'b1;
      gcd_out   = W'(1);
      step();
      chk("mid_ack_high", int'(ack), 1);
      #2 Rst = 1'b0;
      #1;
      chk("arst_ack", int'(ack), 0);
      chk("arst_level", int'(level), 0);
      chk("arst_res_valid", int'(res_valid), 0);
      chk("arst_res_count", int'(res_count), 0);
      chk("arst_coprime_count", int'(coprime_count), 0);
      model_reset();
      gcd_valid = 1'b0;
      repeat (2) step();
      Rst = 1'b1;
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
